// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM states, byte-lane type, lane count.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

   localparam int LANES = 4;

   typedef logic [7:0] byte_lane_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage with one write enable per byte lane; lane 0 is the MSB.
// Latency: combinational read of the addressed word, write commits on posedge clk.
// Backpressure: none; accepts a write on any cycle. Contents survive reset.
module mem_array
   import mem_pkg::*;
#(
   parameter int WORDS = 16384,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic                       clk,
   input  logic [AW-1:0]              addr,
   input  logic [0:LANES-1]           lane_we,
   input  byte_lane_t [0:LANES-1]     wr_dat,
   output byte_lane_t [0:LANES-1]     rd_dat
);

   byte_lane_t [0:LANES-1] mem_q [WORDS];

   // Per-lane write so byte stores leave neighbouring lanes untouched
   always_ff @(posedge clk) begin
      for (int l = 0; l < LANES; l++) begin
         if (lane_we[l]) begin
            mem_q[addr][l] <= wr_dat[l];
         end
      end
   end

   assign rd_dat = mem_q[addr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory target: IDLE/BUSY/DONE FSM over a mem_array; optional
// misaligned-word detection under MEM_MISALIGN_CHECK_EN. Latency: mem_ready
// pulses LATENCY cycles after acceptance; requests are ignored outside IDLE.
module mem_responder
   import mem_pkg::*;
#(
   parameter int LATENCY   = 4,
   parameter int MEM_WORDS = 16384
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    mem_req,
   input  logic [31:0]             mem_addr,
   input  logic                    mem_write_en,
   input  logic                    mem_byte,
   input  byte_lane_t [0:LANES-1]  mem_data_in,
   output byte_lane_t [0:LANES-1]  mem_data_out,
   output logic                    mem_ready,
   output logic                    mem_error
);

   localparam int         AW       = $clog2(MEM_WORDS);
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   state_e                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [AW+1:0]           addr_q, addr_d;
   logic                    we_q, we_d;
   logic                    byte_q, byte_d;
   byte_lane_t [0:LANES-1]  data_q, data_d;
   byte_lane_t [0:LANES-1]  dout_q, dout_d;
   logic                    ready_q, ready_d;

   logic                    commit;
   logic                    misalign;
   logic [0:LANES-1]        lane_sel;
   logic [0:LANES-1]        lane_we;
   byte_lane_t [0:LANES-1]  wr_dat;
   byte_lane_t [0:LANES-1]  rd_dat;

   // Address bits above the wrapped word index are intentionally dropped
   logic                    unused_addr_bits;
   assign unused_addr_bits = ^mem_addr[31:AW+2];

`ifdef MEM_MISALIGN_CHECK_EN
   logic                    error_q, error_d;
`endif

   // Next-state: FSM, countdown, request capture and completion side effects.
   // Completion uses the _d copy of the request so LATENCY=1 can commit on the
   // acceptance edge itself.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      we_d     = we_q;
      byte_d   = byte_q;
      data_d   = data_q;
      dout_d   = dout_q;
      ready_d  = 1'b0;
      commit   = 1'b0;
      misalign = 1'b0;
      lane_we  = '0;

      case (state_q)
         IDLE: begin
            if (mem_req) begin
               addr_d = mem_addr[AW+1:0];
               we_d   = mem_write_en;
               byte_d = mem_byte;
               data_d = mem_data_in;
               if (LATENCY == 1) begin
                  state_d = DONE;
                  ready_d = 1'b1;
                  commit  = 1'b1;
               end else begin
                  state_d = BUSY;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         BUSY: begin
            if (cnt_q <= 4'd1) begin
               state_d = DONE;
               cnt_d   = '0;
               ready_d = 1'b1;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef MEM_MISALIGN_CHECK_EN
      misalign = !byte_d && (addr_d[1:0] != 2'b00);
`endif

      // Byte stores replicate the LSB lane and enable only the addressed lane
      for (int l = 0; l < LANES; l++) begin
         wr_dat[l]   = byte_d ? data_d[LANES-1] : data_d[l];
         lane_sel[l] = (addr_d[1:0] == 2'(l));
      end

      // Reset gates the array write so an aborted store never lands
      if (commit && !reset) begin
         if (we_d && !misalign) begin
            lane_we = byte_d ? lane_sel : '1;
         end
         if (!we_d) begin
            dout_d = misalign ? '0 : rd_dat;
         end
      end

`ifdef MEM_MISALIGN_CHECK_EN
      error_d = error_q | (commit & misalign);
`endif
   end

   // All FSM, counter, request and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         dout_q  <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
         error_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         byte_q  <= byte_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         dout_q  <= dout_d;
`ifdef MEM_MISALIGN_CHECK_EN
         error_q <= error_d;
`endif
      end
   end

   mem_array #(
      .WORDS (MEM_WORDS),
      .AW    (AW)
   ) u_array (
      .clk     (clk),
      .addr    (addr_d[AW+1:2]),
      .lane_we (lane_we),
      .wr_dat  (wr_dat),
      .rd_dat  (rd_dat)
   );

   assign mem_ready    = ready_q;
   assign mem_data_out = dout_q;
`ifdef MEM_MISALIGN_CHECK_EN
   assign mem_error    = error_q;
`else
   assign mem_error    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY=4/MEM_WORDS=16, LATENCY=1/default depth)
// driven with directed and random transactions against a byte-addressed reference model.
// Respects MEM_MISALIGN_CHECK_EN when the same macro is defined for the bench.
module tb_mem_responder;

`ifdef MEM_MISALIGN_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic              req  [2];
   logic              we   [2];
   logic              byt  [2];
   logic [31:0]       addr [2];
   logic [0:3][7:0]   din  [2];
   logic [0:3][7:0]   dout [2];
   logic              rdy  [2];
   logic              err  [2];

   mem_responder #(.LATENCY(4), .MEM_WORDS(16)) dut4 (
      .clk(clk), .reset(reset), .mem_req(req[0]), .mem_addr(addr[0]),
      .mem_write_en(we[0]), .mem_byte(byt[0]), .mem_data_in(din[0]),
      .mem_data_out(dout[0]), .mem_ready(rdy[0]), .mem_error(err[0]));

   mem_responder #(.LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .mem_req(req[1]), .mem_addr(addr[1]),
      .mem_write_en(we[1]), .mem_byte(byt[1]), .mem_data_in(din[1]),
      .mem_data_out(dout[1]), .mem_ready(rdy[1]), .mem_error(err[1]));

   // Reference model: word arrays, last read value and sticky error per instance
   int          words [2] = '{16, 16384};
   int          lats  [2] = '{4, 1};
   logic [31:0] mm    [2][16384];
   logic [31:0] mdout [2];
   bit          merr  [2];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic void model_op(int w, bit e, bit b, logic [31:0] a, logic [31:0] d);
      int idx;
      int sh;
      idx = int'((a >> 2) % 32'(words[w]));
      if (CHK && !b && a[1:0] != 2'b00) begin
         merr[w] = 1'b1;
         if (!e) mdout[w] = '0;
         return;
      end
      if (e) begin
         if (b) begin
            sh = (3 - int'(a[1:0])) * 8;
            mm[w][idx] = (mm[w][idx] & ~(32'hFF << sh)) | (32'(d[7:0]) << sh);
         end else begin
            mm[w][idx] = d;
         end
      end else begin
         mdout[w] = mm[w][idx];
      end
   endfunction

   task automatic drive(input int w, input bit r, input bit e, input bit b,
                        input logic [31:0] a, input logic [31:0] d);
      req[w]  = r;
      we[w]   = e;
      byt[w]  = b;
      addr[w] = a;
      din[w]  = d;
   endtask

   // One request from a negedge; inputs are scrambled after acceptance to show they are ignored
   task automatic xact(input int w, input bit e, input bit b, input logic [31:0] a,
                       input logic [31:0] d, input string tag);
      int lat;
      int k;
      lat = 0;
      k   = 0;
      drive(w, 1'b1, e, b, a, d);
      while (lat == 0 && k < 40) begin
         @(negedge clk);
         k++;
         if (rdy[w]) lat = k;
         else if (k == 1) drive(w, 1'b1, 1'($urandom), 1'($urandom), $urandom, $urandom);
      end
      drive(w, 1'b0, 1'b0, 1'b0, '0, '0);
      model_op(w, e, b, a, d);
      check({tag, "_lat"}, lat, lats[w]);
      check({tag, "_dout"}, dout[w], mdout[w]);
      check({tag, "_err"}, {31'd0, err[w]}, {31'd0, merr[w]});
      @(negedge clk);
      check({tag, "_pulse"}, {31'd0, rdy[w]}, 32'd0);
   endtask

   int          nrdy;
   logic [9:0]  pat;
   logic [31:0] a_r;
   logic [31:0] d_r;

   initial begin
      reset = 1'b1;
      for (int w = 0; w < 2; w++) begin
         drive(w, 1'b0, 1'b0, 1'b0, '0, '0);
         mdout[w] = '0;
         merr[w]  = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         check("rst_rdy", {31'd0, rdy[w]}, 32'd0);
         check("rst_dout", dout[w], 32'd0);
         check("rst_err", {31'd0, err[w]}, 32'd0);
      end

      // Request coinciding with reset must not be accepted
      drive(0, 1'b1, 1'b0, 1'b0, 32'h0, '0);
      @(negedge clk);
      reset = 1'b0;
      drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
      nrdy = 0;
      repeat (8) begin @(negedge clk); nrdy += int'(rdy[0]); end
      check("rst_req_ignored", nrdy, 0);

      // Fill the small instance so every later read is defined
      for (int i = 0; i < 16; i++) xact(0, 1'b1, 1'b0, 32'(i * 4), $urandom, "init");

      xact(0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, "wr100");
      xact(0, 1'b0, 1'b0, 32'h100, '0, "rd100");
      check("deadbeef", dout[0], 32'hDEADBEEF);

      xact(0, 1'b1, 1'b0, 32'h200, 32'h11223344, "wr200");
      xact(0, 1'b1, 1'b1, 32'h202, 32'h000000AA, "byte202");
      xact(0, 1'b0, 1'b0, 32'h200, '0, "rd200");
      check("byte_merge", dout[0], 32'h1122AA44);

      xact(0, 1'b1, 1'b0, 32'h40, 32'hCAFEF00D, "wr40");
      xact(0, 1'b0, 1'b0, 32'h00, '0, "rd00");
      check("wrap", dout[0], 32'hCAFEF00D);

      // Reset two cycles after accepting a write aborts it
      xact(0, 1'b1, 1'b0, 32'h40, 32'h0, "clr40");
      drive(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h12345678);
      nrdy = 0;
      repeat (2) begin @(negedge clk); nrdy += int'(rdy[0]); end
      reset = 1'b1;
      drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
      repeat (2) begin @(negedge clk); nrdy += int'(rdy[0]); end
      reset = 1'b0;
      for (int w = 0; w < 2; w++) begin mdout[w] = '0; merr[w] = 1'b0; end
      check("abort_dout", dout[0], 32'd0);
      repeat (6) begin @(negedge clk); nrdy += int'(rdy[0]); end
      check("abort_no_ready", nrdy, 0);
      xact(0, 1'b0, 1'b0, 32'h40, '0, "rd40");
      check("abort_no_write", dout[0], 32'd0);

      // Misaligned word write
      xact(0, 1'b1, 1'b0, 32'h100, 32'h01020304, "wr100b");
      xact(0, 1'b1, 1'b0, 32'h101, 32'h99887766, "mis101");
      check("mis_err", {31'd0, err[0]}, {31'd0, CHK});
      xact(0, 1'b0, 1'b0, 32'h100, '0, "rd100b");
      check("mis_data", dout[0], CHK ? 32'h01020304 : 32'h99887766);

      for (int i = 0; i < 60; i++)
         xact(0, 1'($urandom), ($urandom % 4) == 0, $urandom, $urandom, "rnd4");

      // LATENCY=1 instance
      xact(1, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, "l1_wr");
      xact(1, 1'b0, 1'b0, 32'h100, '0, "l1_rd");
      check("l1_deadbeef", dout[1], 32'hDEADBEEF);
      for (int i = 0; i < 12; i++) begin
         a_r = $urandom & 32'hFFFF_FFFC;
         d_r = $urandom;
         xact(1, 1'b1, 1'b0, a_r, d_r, "l1_rw");
         if ($urandom % 2) xact(1, 1'b1, 1'b1, a_r | 32'($urandom % 4), $urandom, "l1_rb");
         xact(1, 1'b0, 1'b0, a_r, '0, "l1_rr");
      end

      // Request held high: ready spacing is LATENCY+1
      drive(1, 1'b1, 1'b0, 1'b0, 32'h100, '0);
      pat = '0;
      for (int k = 0; k < 6; k++) begin @(negedge clk); pat = {pat[8:0], rdy[1]}; end
      drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
      model_op(1, 1'b0, 1'b0, 32'h100, '0);
      check("l1_spacing", {22'd0, pat}, 32'b101010);
      check("l1_spacing_dout", dout[1], mdout[1]);

      drive(0, 1'b1, 1'b0, 1'b0, 32'h100, '0);
      pat = '0;
      for (int k = 0; k < 10; k++) begin @(negedge clk); pat = {pat[8:0], rdy[0]}; end
      drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
      model_op(0, 1'b0, 1'b0, 32'h100, '0);
      check("l4_spacing", {22'd0, pat}, 32'b0001000010);
      check("l4_spacing_dout", dout[0], mdout[0]);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
